cache_refill_ctrl: RTL and testbench

//  Downstream stage of the 2-way write-back data cache: services line misses against a
//  32-entry main memory model. On a miss it first commits the evicted dirty line (when
//  the cache flags write-back), then fetches the requested line and returns it to the

---
 rtl/cache_refill_ctrl_pkg.sv | 23 ++
 rtl/cache_refill_ctrl_if.sv | 32 +++
 rtl/cache_refill_ctrl_main_mem.sv | 43 ++++
 rtl/cache_refill_ctrl.sv | 124 ++++++++++++
 tb/tb_cache_refill_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_refill_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Package  : cache_pkg
// Purpose  : Geometry constants and refill state encoding shared with the cache.
// Revision : 1.0
// ---------------------------------------------------------------------------
package cache_pkg;

    localparam int DATA_W    = 3;
    localparam int TAG_W     = 3;
    localparam int IDX_W     = 2;
    localparam int ADDR_W    = TAG_W + IDX_W;
    localparam int MEM_DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        RS_IDLE = 2'd0,
        RS_WB   = 2'd1,
        RS_FILL = 2'd2,
        RS_RESP = 2'd3
    } refill_state_e;

endpackage
`default_nettype wire

// File: rtl/cache_refill_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Interface : cache_refill_ctrl_if
// Purpose   : Miss request / fill response channel between cache and refill.
// Revision  : 1.0
// ---------------------------------------------------------------------------
interface cache_refill_ctrl_if;
    import cache_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wback;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              busy;

    modport master (
        output req_valid, req_addr, req_wback, wb_addr, wb_data, resp_ready,
        input  req_ready, resp_valid, resp_data, busy
    );

    modport slave (
        input  req_valid, req_addr, req_wback, wb_addr, wb_data, resp_ready,
        output req_ready, resp_valid, resp_data, busy
    );

endinterface
`default_nettype wire

// File: rtl/cache_refill_ctrl_main_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : cache_main_mem
// Purpose  : 2^ADDR_W x DATA_W main memory, single port, sync write, registered read.
// Revision : 1.0
// ---------------------------------------------------------------------------
module cache_main_mem
    import cache_pkg::*;
(
    input  wire logic              clock,
    input  wire logic              reset_n,
    input  wire logic              i_we,
    input  wire logic              i_re,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [DATA_W-1:0] i_wdata,
    output logic      [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] w_words [MEM_DEPTH];

    // Array contents survive reset; each word powers up holding its own low address bits.
    for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_word
        logic [DATA_W-1:0] r_word = DATA_W'(gi);

        always_ff @(posedge clock) begin
            if (i_we && (i_addr == ADDR_W'(gi))) begin
                r_word <= i_wdata;
            end
        end

        assign w_words[gi] = r_word;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= w_words[i_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : cache_refill_ctrl
// Purpose  : Miss service FSM: optional victim write-back, line fetch, fill response.
//            Macro REFILL_STATS_EN adds saturating fill_cnt / wb_cnt outputs.
// Revision : 1.0
// ---------------------------------------------------------------------------
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int MEM_LAT = 2
)
(
    input  wire logic            clock,
    input  wire logic            reset_n,
    cache_refill_ctrl_if.slave   bus
`ifdef REFILL_STATS_EN
    ,
    output logic [7:0]           fill_cnt,
    output logic [7:0]           wb_cnt
`endif
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    localparam logic [1:0] c_idle = 2'(RS_IDLE);
    localparam logic [1:0] c_wb   = 2'(RS_WB);
    localparam logic [1:0] c_fill = 2'(RS_FILL);
    localparam logic [1:0] c_resp = 2'(RS_RESP);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_req_addr;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;
    logic              w_last;
    logic              w_accept;
    logic              w_hs;
    logic              w_mem_we;
    logic              w_mem_re;

    assign w_last   = (r_cnt == CNT_W'(MEM_LAT - 1));
    assign w_accept = bus.req_valid && (r_state == c_idle);
    assign w_hs     = bus.resp_ready && (r_state == c_resp);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: if (w_accept) w_state_nxt = bus.req_wback ? c_wb : c_fill;
            c_wb:   if (w_last)   w_state_nxt = c_fill;
            c_fill: if (w_last)   w_state_nxt = c_resp;
            c_resp: if (w_hs)     w_state_nxt = c_idle;
            default:              w_state_nxt = c_idle;
        endcase
    end

    // Latency counter restarts from zero whenever the state changes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_idle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == c_wb) || (r_state == c_fill)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_req_addr <= '0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
        end else if (w_accept) begin
            r_req_addr <= bus.req_addr;
            r_wb_addr  <= bus.wb_addr;
            r_wb_data  <= bus.wb_data;
        end
    end

    assign w_mem_we = (r_state == c_wb) && w_last;
    assign w_mem_re = (r_state == c_fill) && w_last;

    // Write and fetch never coincide, so one port serves both phases.
    cache_main_mem u_mem (
        .clock   (clock),
        .reset_n (reset_n),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  ((r_state == c_wb) ? r_wb_addr : r_req_addr),
        .i_wdata (r_wb_data),
        .o_rdata (bus.resp_data)
    );

    assign bus.req_ready  = (r_state == c_idle);
    assign bus.busy       = (r_state != c_idle);
    assign bus.resp_valid = (r_state == c_resp);

`ifdef REFILL_STATS_EN
    logic [7:0] r_fill_cnt;
    logic [7:0] r_wb_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fill_cnt <= '0;
            r_wb_cnt   <= '0;
        end else begin
            if (w_hs && (r_fill_cnt != 8'hFF)) r_fill_cnt <= r_fill_cnt + 8'd1;
            if (w_mem_we && (r_wb_cnt != 8'hFF)) r_wb_cnt <= r_wb_cnt + 8'd1;
        end
    end

    assign fill_cnt = r_fill_cnt;
    assign wb_cnt   = r_wb_cnt;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_cache_refill_ctrl
// Purpose  : Self-checking bench for cache_refill_ctrl against a memory-array model.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_cache_refill_ctrl;
    import cache_pkg::*;

    localparam int MEM_LAT = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    cache_refill_ctrl_if bus();

`ifdef REFILL_STATS_EN
    logic [7:0] fill_cnt;
    logic [7:0] wb_cnt;
`endif

    cache_refill_ctrl #(.MEM_LAT(MEM_LAT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef REFILL_STATS_EN
        ,
        .fill_cnt(fill_cnt),
        .wb_cnt  (wb_cnt)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [DATA_W-1:0] ref_mem [MEM_DEPTH];

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              wback;
        logic [ADDR_W-1:0] wb_addr;
        logic [DATA_W-1:0] wb_data;
        logic [DATA_W-1:0] exp_data;
        int                exp_lat;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: a transaction writes the victim (if dirty) then returns the requested word.
    function automatic logic [DATA_W-1:0] ref_txn(input logic [ADDR_W-1:0] addr,
                                                  input logic wback,
                                                  input logic [ADDR_W-1:0] wa,
                                                  input logic [DATA_W-1:0] wd);
        if (wback) ref_mem[wa] = wd;
        return ref_mem[addr];
    endfunction

    task automatic scramble();
        bus.req_addr  = ADDR_W'($urandom);
        bus.wb_addr   = ADDR_W'($urandom);
        bus.wb_data   = DATA_W'($urandom);
        bus.req_wback = 1'($urandom);
    endtask

    task automatic run_txn(input logic [ADDR_W-1:0] addr, input logic wback,
                           input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                           input int hold, input bit poke,
                           output logic [DATA_W-1:0] data, output int lat);
        int guard = 0;
        while (!bus.req_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        @(negedge clock);
        bus.req_addr  = addr;
        bus.req_wback = wback;
        bus.wb_addr   = wa;
        bus.wb_data   = wd;
        bus.req_valid = 1'b1;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        scramble();
        chk("accept_busy_ready", {bus.busy, bus.req_ready}, 2'b10);
        lat = 0;
        while (!bus.resp_valid && lat < 64) begin
            @(posedge clock); #1;
            lat++;
        end
        data = bus.resp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            if (poke) begin
                bus.req_valid = 1'b1;
                bus.req_addr  = ADDR_W'($urandom);
            end
            @(posedge clock); #1;
            bus.req_valid = 1'b0;
            if (poke)
                chk("backpressure_stable",
                    {bus.resp_valid, bus.req_ready, bus.busy, bus.resp_data},
                    {3'b101, data});
        end
        @(negedge clock);
        bus.resp_ready = 1'b1;
        @(posedge clock); #1;
        bus.resp_ready = 1'b0;
        chk("handshake_to_idle", {bus.resp_valid, bus.req_ready, bus.busy}, 3'b010);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, {bus.req_ready, bus.resp_valid, bus.busy, bus.resp_data}, {3'b100, 3'b000});
    endtask

    // Accept a request, let 'edges' further edges pass, then reset between edges.
    task automatic abort_txn(input logic [ADDR_W-1:0] addr, input logic wback,
                             input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                             input int edges, input string name);
        @(negedge clock);
        bus.req_addr  = addr;
        bus.req_wback = wback;
        bus.wb_addr   = wa;
        bus.wb_data   = wd;
        bus.req_valid = 1'b1;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        for (int i = 0; i < edges; i++) @(posedge clock);
        #2 reset_n = 1'b0;
        #1 chk_reset_outputs(name);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DATA_W-1:0] got;
        logic [DATA_W-1:0] nd;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic              wb;
        logic [DATA_W-1:0] exp;
        int                lat;

        for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = DATA_W'(i);

        vecs[0] = '{5'b01110, 1'b0, 5'b00000, 3'b000, 3'b110, 2};
        vecs[1] = '{5'b10001, 1'b1, 5'b00001, 3'b111, 3'b001, 4};
        vecs[2] = '{5'b00001, 1'b0, 5'b00000, 3'b000, 3'b111, 2};
        vecs[3] = '{5'b11010, 1'b1, 5'b11010, 3'b101, 3'b101, 4};

        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        bus.req_addr   = '0;
        bus.req_wback  = 1'b0;
        bus.wb_addr    = '0;
        bus.wb_data    = '0;

        #12 chk_reset_outputs("reset_state");
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_txn(vecs[i].addr, vecs[i].wback, vecs[i].wb_addr, vecs[i].wb_data, 0, 1'b0, got, lat);
            void'(ref_txn(vecs[i].addr, vecs[i].wback, vecs[i].wb_addr, vecs[i].wb_data));
            chk($sformatf("vec%0d_data", i), 32'(got), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
        end

        // Back-pressure with ignored request pulses, then a back-to-back request.
        exp = ref_txn(5'b00111, 1'b0, '0, '0);
        run_txn(5'b00111, 1'b0, '0, '0, 5, 1'b1, got, lat);
        chk("backpressure_data", 32'(got), 32'(exp));
        exp = ref_txn(5'b01001, 1'b0, '0, '0);
        run_txn(5'b01001, 1'b0, '0, '0, 0, 1'b0, got, lat);
        chk("back_to_back_data", 32'(got), 32'(exp));
        exp = ref_txn(5'b00111, 1'b0, '0, '0);
        run_txn(5'b00111, 1'b0, '0, '0, 0, 1'b0, got, lat);
        chk("nonzero_before_reset", 32'(got), 32'(exp));

        abort_txn(5'b00100, 1'b0, '0, '0, 1, "reset_mid_fill");

        // Reset one edge into WB: the write never lands.
        nd = ~ref_mem[5'b01011];
        abort_txn(5'b00010, 1'b1, 5'b01011, nd, 1, "reset_mid_wb_early");
        exp = ref_txn(5'b01011, 1'b0, '0, '0);
        run_txn(5'b01011, 1'b0, '0, '0, 0, 1'b0, got, lat);
        chk("wb_aborted_mem_unchanged", 32'(got), 32'(exp));

        // Reset after the write edge: the write is retained.
        nd = ~ref_mem[5'b01100];
        abort_txn(5'b00010, 1'b1, 5'b01100, nd, 2, "reset_after_wb_write");
        ref_mem[5'b01100] = nd;
        exp = ref_txn(5'b01100, 1'b0, '0, '0);
        run_txn(5'b01100, 1'b0, '0, '0, 0, 1'b0, got, lat);
        chk("wb_write_retained", 32'(got), 32'(exp));

        for (int i = 0; i < 40; i++) begin
            a  = ADDR_W'($urandom);
            wb = 1'($urandom);
            wa = ($urandom_range(0, 3) == 0) ? a : ADDR_W'($urandom);
            wd = DATA_W'($urandom);
            exp = ref_txn(a, wb, wa, wd);
            run_txn(a, wb, wa, wd, $urandom_range(0, 3), 1'($urandom), got, lat);
            chk($sformatf("rand%0d_data", i), 32'(got), 32'(exp));
            chk($sformatf("rand%0d_latency", i), lat, wb ? 2 * MEM_LAT : MEM_LAT);
        end

`ifdef REFILL_STATS_EN
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        chk("stats_reset", {fill_cnt, wb_cnt}, 16'h0000);
        for (int i = 0; i < 300; i++) begin
            a = ADDR_W'($urandom);
            exp = ref_txn(a, 1'b0, '0, '0);
            run_txn(a, 1'b0, '0, '0, 0, 1'b0, got, lat);
        end
        chk("stats_fill_saturated", fill_cnt, 8'd255);
        chk("stats_wb_zero", wb_cnt, 8'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
